responder_ctrl: RTL and testbench

//   Quiz-responder arbitration controller for the contestant buttons.
//   - Host arms a round; the first contestant to press locks out all others.
//   - Runs a per-round answer countdown and flags early presses (fouls).
//   - Drives winner, countdown and buzzer outputs for display/LED logic.
//   - Sits between the synchronised/debounced button inputs and the display decoders.

---
 rtl/responder_pkg.sv | 34 +++
 rtl/responder_tick_gen.sv | 35 +++
 rtl/responder_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_responder_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/responder_pkg.sv
// Shared types and helpers for the quiz-responder controller.
// Holds the FSM state encoding and the round-robin tie-break picker.
package responder_pkg;

  localparam int MAX_PLAYERS = 8;
  localparam int PW          = $clog2(MAX_PLAYERS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    LOCKED  = 3'd2,
    TIMEOUT = 3'd3,
    FOUL    = 3'd4
  } state_t;

  // First requesting index at or after ptr, scanning modulo n.
  // Returns 0 when nothing is requested; callers only use it on a real press.
  function automatic int unsigned rr_pick(input logic [MAX_PLAYERS-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_pick = 32'd0;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_PLAYERS; k++) begin
      idx = (ptr + k) % n;
      if (!found && (k < n) && req[idx[PW-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/responder_tick_gen.sv
// One-second prescaler for the answer countdown.
// Emits a single-cycle tick on the last cycle of each CLK_PER_SEC window.
module responder_tick_gen
  import responder_pkg::*;
#(
  parameter int CLK_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

  logic [CW-1:0] count_r;

  assign tick = en && (count_r == LAST);

  // prescaler counter: cleared outside the armed window, wraps at LAST
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en) begin
      count_r <= (count_r == LAST) ? {CW{1'b0}} : count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/responder_ctrl.sv
// Quiz-responder arbitration: arm, first-press lockout with round-robin
// tie-break, per-round countdown, foul detection and buzzer pulse.
module responder_ctrl
  import responder_pkg::*;
#(
  parameter int N_PLAYERS   = 4,
  parameter int CLK_PER_SEC = 50000000,
  parameter int ANSWER_SEC  = 10,
  parameter int BUZZ_CYCLES = 25000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic [N_PLAYERS-1:0]         btn,
  output logic [N_PLAYERS-1:0]         winner_onehot,
  output logic [$clog2(N_PLAYERS)-1:0] winner_id,
  output logic                         winner_valid,
  output logic                         armed,
  output logic [3:0]                   countdown,
  output logic                         timeout,
  output logic                         foul,
  output logic                         buzzer
);

  localparam int IW = $clog2(N_PLAYERS);
  localparam int BW = $clog2(BUZZ_CYCLES + 1);

  state_t                 state_r, state_s;
  logic                   start_q_r, clear_q_r;
  logic [N_PLAYERS-1:0]   btn_q_r;
  logic [IW-1:0]          rr_ptr_r, rr_ptr_s;
  logic [BW-1:0]          buzz_cnt_r, buzz_cnt_s;
  logic [N_PLAYERS-1:0]   onehot_r, onehot_s;
  logic [IW-1:0]          id_r, id_s;
  logic                   valid_r, valid_s;
  logic                   armed_r, armed_s;
  logic [3:0]             countdown_r, countdown_s;
  logic                   timeout_r, timeout_s;
  logic                   foul_r, foul_s;
  logic                   buzzer_r, buzzer_s;

  logic                   start_edge_s, clear_edge_s, press_any_s, tick_s;
  logic [N_PLAYERS-1:0]   press_s, win_onehot_s;
  logic [MAX_PLAYERS-1:0] req_s;
  logic [IW-1:0]          win_s, low_s, rr_next_s;

  assign start_edge_s = start & ~start_q_r;
  assign clear_edge_s = clear & ~clear_q_r;
  assign press_s      = btn & ~btn_q_r;
  assign press_any_s  = |press_s;
  assign win_s        = IW'(rr_pick(req_s, 32'(rr_ptr_r), 32'(N_PLAYERS)));
  assign low_s        = IW'(rr_pick(req_s, 32'd0, 32'(N_PLAYERS)));
  assign rr_next_s    = (win_s == IW'(N_PLAYERS - 1)) ? {IW{1'b0}} : win_s + IW'(1);

  responder_tick_gen #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_r != ARMED),
    .en   (state_r == ARMED),
    .tick (tick_s)
  );

  // widen presses for the picker and decode the round-robin winner
  always_comb begin
    req_s                = {MAX_PLAYERS{1'b0}};
    req_s[N_PLAYERS-1:0] = press_s;
    win_onehot_s         = {N_PLAYERS{1'b0}};
    win_onehot_s[win_s]  = 1'b1;
  end

  // next state and next registered outputs; clear outranks every event
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    onehot_s    = onehot_r;
    id_s        = id_r;
    valid_s     = valid_r;
    armed_s     = armed_r;
    countdown_s = countdown_r;
    timeout_s   = timeout_r;
    foul_s      = foul_r;
    buzz_cnt_s  = (buzz_cnt_r != {BW{1'b0}}) ? buzz_cnt_r - BW'(1) : {BW{1'b0}};
    if (clear_edge_s) begin
      state_s     = IDLE;
      onehot_s    = {N_PLAYERS{1'b0}};
      id_s        = {IW{1'b0}};
      valid_s     = 1'b0;
      armed_s     = 1'b0;
      countdown_s = 4'd0;
      timeout_s   = 1'b0;
      foul_s      = 1'b0;
      buzz_cnt_s  = {BW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (press_any_s) begin
            state_s    = FOUL;
            id_s       = low_s;
            foul_s     = 1'b1;
            buzz_cnt_s = BW'(BUZZ_CYCLES);
          end else if (start_edge_s) begin
            state_s     = ARMED;
            armed_s     = 1'b1;
            countdown_s = 4'(ANSWER_SEC);
          end else begin
            state_s = IDLE;
          end
        end
        ARMED: begin
          if (press_any_s) begin
            // countdown keeps its pre-tick value: a press beats expiry
            state_s    = LOCKED;
            onehot_s   = win_onehot_s;
            id_s       = win_s;
            valid_s    = 1'b1;
            armed_s    = 1'b0;
            rr_ptr_s   = rr_next_s;
            buzz_cnt_s = BW'(BUZZ_CYCLES);
          end else if (tick_s) begin
            if (countdown_r <= 4'd1) begin
              state_s     = TIMEOUT;
              armed_s     = 1'b0;
              timeout_s   = 1'b1;
              countdown_s = 4'd0;
            end else begin
              countdown_s = countdown_r - 4'd1;
            end
          end else begin
            state_s = ARMED;
          end
        end
        TIMEOUT: begin
          if (start_edge_s) begin
            state_s     = ARMED;
            armed_s     = 1'b1;
            timeout_s   = 1'b0;
            countdown_s = 4'(ANSWER_SEC);
          end else begin
            state_s = TIMEOUT;
          end
        end
        LOCKED:  state_s = LOCKED;
        FOUL:    state_s = FOUL;
        default: state_s = IDLE;
      endcase
    end
    buzzer_s = (buzz_cnt_s != {BW{1'b0}});
  end

  // state, edge-detect history and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      start_q_r   <= 1'b0;
      clear_q_r   <= 1'b0;
      btn_q_r     <= {N_PLAYERS{1'b0}};
      rr_ptr_r    <= {IW{1'b0}};
      buzz_cnt_r  <= {BW{1'b0}};
      onehot_r    <= {N_PLAYERS{1'b0}};
      id_r        <= {IW{1'b0}};
      valid_r     <= 1'b0;
      armed_r     <= 1'b0;
      countdown_r <= 4'd0;
      timeout_r   <= 1'b0;
      foul_r      <= 1'b0;
      buzzer_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      start_q_r   <= start;
      clear_q_r   <= clear;
      btn_q_r     <= btn;
      rr_ptr_r    <= rr_ptr_s;
      buzz_cnt_r  <= buzz_cnt_s;
      onehot_r    <= onehot_s;
      id_r        <= id_s;
      valid_r     <= valid_s;
      armed_r     <= armed_s;
      countdown_r <= countdown_s;
      timeout_r   <= timeout_s;
      foul_r      <= foul_s;
      buzzer_r    <= buzzer_s;
    end
  end

  assign winner_onehot = onehot_r;
  assign winner_id     = id_r;
  assign winner_valid  = valid_r;
  assign armed         = armed_r;
  assign countdown     = countdown_r;
  assign timeout       = timeout_r;
  assign foul          = foul_r;
  assign buzzer        = buzzer_r;

endmodule

// File: tb/tb_responder_ctrl.sv
// Scoreboard bench for responder_ctrl: directed rounds then random traffic,
// checked every cycle against an elapsed-time reference model.
module tb_responder_ctrl;

  localparam int N   = 4;
  localparam int CPS = 10;
  localparam int ANS = 3;
  localparam int BZ  = 4;

  localparam int M_IDLE = 0, M_ARMED = 1, M_LOCKED = 2, M_TIMEOUT = 3, M_FOUL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] btn = 4'b0000;

  logic [3:0] winner_onehot;
  logic [1:0] winner_id;
  logic       winner_valid, armed, timeout, foul, buzzer;
  logic [3:0] countdown;

  responder_ctrl #(
    .N_PLAYERS(N), .CLK_PER_SEC(CPS), .ANSWER_SEC(ANS), .BUZZ_CYCLES(BZ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .btn(btn),
    .winner_onehot(winner_onehot), .winner_id(winner_id),
    .winner_valid(winner_valid), .armed(armed), .countdown(countdown),
    .timeout(timeout), .foul(foul), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] oh;
    logic [1:0] id;
    logic       valid;
    logic       arm;
    logic [3:0] cd;
    logic       to;
    logic       fl;
    logic       bz;
  } obs_t;

  obs_t  exp_q[$];
  string lbl_q[$];
  int    errors = 0;
  int    checks = 0;

  // reference model: time since arming, not a prescaler
  int         mode = M_IDLE;
  int         e = 0, arm_e = 0, w = 0, rr = 0, cd = 0, buzz_e = -1000;
  logic       ps = 1'b0, pc = 1'b0;
  logic [3:0] pb = 4'b0000;

  function automatic int pick(input logic [3:0] req, input int from);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (from + k) % N;
      if (req[i[1:0]]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic s, input logic c, input logic [3:0] b,
                            input logic r, output obs_t x);
    logic       se, ce;
    logic [3:0] pr;
    int         k;
    e++;
    if (!r) begin
      mode = M_IDLE; rr = 0; w = 0; cd = 0; buzz_e = -1000;
      ps = 1'b0; pc = 1'b0; pb = 4'b0000;
    end else begin
      se = s && !ps; ce = c && !pc; pr = b & ~pb;
      ps = s; pc = c; pb = b;
      k = e - arm_e;
      if (ce) begin
        mode = M_IDLE; w = 0; cd = 0; buzz_e = -1000;
      end else begin
        case (mode)
          M_IDLE:
            if (pr != 4'b0000) begin
              mode = M_FOUL; w = pick(pr, 0); buzz_e = e;
            end else if (se) begin
              mode = M_ARMED; arm_e = e; cd = ANS;
            end
          M_ARMED:
            if (pr != 4'b0000) begin
              mode = M_LOCKED; w = pick(pr, rr); rr = (w + 1) % N;
              cd = ANS - (k - 1) / CPS; buzz_e = e;
            end else begin
              cd = ANS - k / CPS;
              if (cd <= 0) begin cd = 0; mode = M_TIMEOUT; end
            end
          M_TIMEOUT:
            if (se) begin mode = M_ARMED; arm_e = e; cd = ANS; end
          default: ;
        endcase
      end
    end
    x.oh    = (mode == M_LOCKED) ? 4'(1 << w) : 4'b0000;
    x.id    = (mode == M_LOCKED || mode == M_FOUL) ? 2'(w) : 2'd0;
    x.valid = (mode == M_LOCKED);
    x.arm   = (mode == M_ARMED);
    x.cd    = (mode == M_ARMED || mode == M_LOCKED) ? 4'(cd) : 4'd0;
    x.to    = (mode == M_TIMEOUT);
    x.fl    = (mode == M_FOUL);
    x.bz    = (e - buzz_e >= 0) && (e - buzz_e < BZ);
  endtask

  task automatic drive(input logic s, input logic c, input logic [3:0] b,
                       input logic r, input string l);
    obs_t x;
    @(negedge clk);
    start = s; clear = c; btn = b; rst_n = r;
    model_edge(s, c, b, r, x);
    exp_q.push_back(x);
    lbl_q.push_back(l);
  endtask

  task automatic idle(input int n, input string l);
    repeat (n) drive(1'b0, 1'b0, 4'b0000, 1'b1, l);
  endtask

  // monitor: one expected snapshot per clock edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t  a, x;
        string l;
        x = exp_q.pop_front();
        l = lbl_q.pop_front();
        a = {winner_onehot, winner_id, winner_valid, armed, countdown, timeout, foul, buzzer};
        checks++;
        if (a !== x) begin
          errors++;
          $display("FAIL %s @%0t: got oh=%b id=%0d v=%b arm=%b cd=%0d to=%b foul=%b bz=%b, expected oh=%b id=%0d v=%b arm=%b cd=%0d to=%b foul=%b bz=%b",
                   l, $time, a.oh, a.id, a.valid, a.arm, a.cd, a.to, a.fl, a.bz,
                   x.oh, x.id, x.valid, x.arm, x.cd, x.to, x.fl, x.bz);
        end
      end
    end
  end

  initial begin
    // power-up reset
    drive(1'b0, 1'b0, 4'b0000, 1'b0, "reset");
    drive(1'b0, 1'b0, 4'b0000, 1'b0, "reset");
    idle(2, "reset_idle");

    // single press lock, buzzer length, lockout of later presses
    drive(1'b1, 1'b0, 4'b0000, 1'b1, "lock_start");
    idle(5, "lock_armed");
    repeat (3) drive(1'b0, 1'b0, 4'b0100, 1'b1, "lock_press");
    idle(6, "lock_buzz");
    repeat (2) drive(1'b1, 1'b0, 4'b0001, 1'b1, "lock_ignore");
    drive(1'b0, 1'b1, 4'b0000, 1'b1, "lock_clear");
    idle(2, "lock_cleared");

    // simultaneous presses resolved round-robin from a fresh pointer
    drive(1'b0, 1'b0, 4'b0000, 1'b0, "rr_reset");
    drive(1'b0, 1'b0, 4'b0000, 1'b0, "rr_reset");
    drive(1'b1, 1'b0, 4'b0000, 1'b1, "rr_start1");
    drive(1'b0, 1'b0, 4'b1010, 1'b1, "rr_press1");
    idle(5, "rr_hold1");
    drive(1'b0, 1'b1, 4'b0000, 1'b1, "rr_clear1");
    drive(1'b1, 1'b0, 4'b0000, 1'b1, "rr_start2");
    drive(1'b0, 1'b0, 4'b1010, 1'b1, "rr_press2");
    idle(5, "rr_hold2");
    drive(1'b0, 1'b1, 4'b0000, 1'b1, "rr_clear2");

    // countdown to timeout, re-arm, then press exactly on expiry
    drive(1'b1, 1'b0, 4'b0000, 1'b1, "to_start");
    idle(35, "to_count");
    drive(1'b1, 1'b0, 4'b0000, 1'b1, "to_rearm");
    idle(29, "to_count2");
    drive(1'b0, 1'b0, 4'b0010, 1'b1, "to_press_expiry");
    idle(6, "to_locked");
    drive(1'b0, 1'b1, 4'b0000, 1'b1, "to_clear");
    idle(1, "to_cleared");

    // early press is a foul; start ignored; clear zeroes everything
    drive(1'b0, 1'b0, 4'b1000, 1'b1, "foul_press");
    idle(2, "foul_hold");
    drive(1'b1, 1'b0, 4'b0000, 1'b1, "foul_start_ign");
    idle(3, "foul_hold2");
    drive(1'b0, 1'b1, 4'b0000, 1'b1, "foul_clear");
    idle(2, "foul_cleared");

    // reset mid-round aborts
    drive(1'b1, 1'b0, 4'b0000, 1'b1, "rst_start");
    idle(12, "rst_armed");
    drive(1'b0, 1'b0, 4'b0000, 1'b0, "rst_mid");
    idle(3, "rst_after");

    // randomized traffic
    begin
      logic [3:0] rb;
      rb = 4'b0000;
      for (int i = 0; i < 2000; i++) begin
        logic s, c, r;
        s = ($urandom_range(0, 24) == 0);
        c = ($urandom_range(0, 59) == 0);
        r = ($urandom_range(0, 499) != 0);
        if ($urandom_range(0, 15) == 0) rb = 4'($urandom);
        drive(s, c, rb, r, "random");
      end
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected snapshots never compared, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
